// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl
// Brief    : Iterative signed multiply/divide sequencer (radix-2 shift-add /
//            restoring shift-subtract) sharing one WIDTH+1-bit adder.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0]    c_LAST   = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]    c_CNT1   = c_CW'(1);
    localparam logic [WIDTH-1:0]   c_ONE    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_ONE2   = (2*WIDTH)'(1);
    localparam logic [WIDTH:0]     c_ONE_A  = (WIDTH+1)'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;

    logic               w_start;
    logic               w_start_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_add_a;
    logic [WIDTH:0]     w_add_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic               w_mul_ovf;

    assign w_start     = ((r_state == c_IDLE) || (r_state == c_DONE)) && (ctrl_MULT || ctrl_DIV);
    assign w_start_div = ~ctrl_MULT;

    // |-2^(WIDTH-1)| wraps to the same bit pattern, which reads correctly as unsigned
    assign w_mag_a = data_operandA[WIDTH-1] ? (~data_operandA + c_ONE) : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? (~data_operandB + c_ONE) : data_operandB;

    // Divide: remainder shifted left with the next dividend bit pulled in from the quotient half
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};

    always_comb begin
        w_add_a = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        w_add_b = {1'b0, r_opnd};
        if (r_is_div) begin
            w_add_a = w_rem_sh;
            w_add_b = ~{1'b0, r_opnd} + c_ONE_A;
        end
    end

    assign w_sum = w_add_a + w_add_b;

    assign w_prod_s  = r_neg ? (~r_acc + c_ONE2) : r_acc;
    assign w_quo_s   = r_neg ? (~r_acc[WIDTH-1:0] + c_ONE) : r_acc[WIDTH-1:0];
    assign w_mul_ovf = ~((&w_prod_s[2*WIDTH-1:WIDTH-1]) | ~(|w_prod_s[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_dbz    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_start) begin
                        r_state  <= c_RUN;
                        r_cnt    <= '0;
                        r_is_div <= w_start_div;
                        r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        r_dbz    <= w_start_div && (data_operandB == '0);
                        r_opnd   <= w_start_div ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (w_start_div ? w_mag_a : w_mag_b)};
                    end else begin
                        r_state  <= c_IDLE;
                    end
                end
                c_RUN: begin
                    if (r_is_div) begin
                        // A set borrow bit means the trial went negative: keep the old remainder
                        if (w_sum[WIDTH])
                            r_acc <= {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                        else
                            r_acc <= {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    end else begin
                        if (r_acc[0])
                            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                        else
                            r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + c_CNT1;
                    if (r_cnt == c_LAST)
                        r_state <= c_FIX;
                end
                c_FIX: begin
                    r_state <= c_DONE;
                    if (!r_is_div) begin
                        r_result <= w_prod_s[WIDTH-1:0];
                        r_exc    <= w_mul_ovf;
                    end else if (r_dbz) begin
                        r_result <= '0;
                        r_exc    <= 1'b1;
                    end else begin
                        // Only -2^(WIDTH-1) / -1 yields a positive quotient with the top bit set
                        r_result <= w_quo_s;
                        r_exc    <= r_acc[WIDTH-1] & ~r_neg;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == c_DONE);
    assign busy           = (r_state == c_RUN) || (r_state == c_FIX);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_ctrl
// Brief    : Randomized and directed bench for multdiv_ctrl against a
//            cycle-count / 64-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic          ctrl_MULT = 1'b0;
    logic          ctrl_DIV  = 1'b0;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit            m_active = 1'b0;
    int            m_left   = 0;
    logic [W-1:0]  m_pend_res = '0;
    bit            m_pend_exc = 1'b0;
    logic [W-1:0]  m_res = '0;
    bit            m_exc = 1'b0;
    bit            m_rdy = 1'b0;

    multdiv_ctrl #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic void ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit e);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (mul) begin
            p = sa * sb;
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (sb == 0) begin
            r = '0;
            e = 1'b1;
        end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    // One clock edge: advance the model with the inputs the DUT just sampled, then compare
    task automatic tick();
        bit pre_active;
        @(posedge clock);
        pre_active = m_active;
        m_rdy = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_left   = 0;
            m_res    = '0;
            m_exc    = 1'b0;
        end else begin
            if (m_active) begin
                m_left--;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    m_res    = m_pend_res;
                    m_exc    = m_pend_exc;
                    m_rdy    = 1'b1;
                end
            end
            if (!pre_active && (ctrl_MULT || ctrl_DIV)) begin
                ref_op(ctrl_MULT, data_operandA, data_operandB, m_pend_res, m_pend_exc);
                m_active = 1'b1;
                m_left   = W + 1;
            end
        end
        #1;
        chk("result", data_result, m_res);
        chk("exception", 32'(data_exception), 32'(m_exc));
        chk("resultRDY", 32'(data_resultRDY), 32'(m_rdy));
        chk("busy", 32'(busy), 32'(m_active));
    endtask

    task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = mul;
        ctrl_DIV  = div;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (data_resultRDY) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL rdy_timeout: got=no_rdy expected=rdy within 40 cycles at t=%0t", $time);
        end
    endtask

    task automatic directed(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input bit ee);
        int n;
        start_op(mul, div, a, b);
        wait_rdy(n);
        chk("latency", n, 33);
        chk("lit_result", data_result, er);
        chk("lit_exception", 32'(data_exception), 32'(ee));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: rnd_val = 32'h0000_0000;
            1: rnd_val = 32'h0000_0001;
            2: rnd_val = 32'hFFFF_FFFF;
            3: rnd_val = 32'h8000_0000;
            4: rnd_val = 32'h7FFF_FFFF;
            5: rnd_val = 32'($urandom_range(0, 40)) - 32'd20;
            default: rnd_val = $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int rdy_cnt;
        bit mul;
        bit div;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_result", data_result, 32'h0);
        chk("reset_flags", {29'b0, data_exception, data_resultRDY, busy}, 32'h0);

        directed(1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        tick();
        chk("busy_after", 32'(busy), 32'h0);
        directed(1, 0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        directed(1, 0, 32'hFFFF_0000, 32'd32768, 32'h8000_0000, 1'b0);
        directed(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        directed(0, 1, 32'd100, 32'd0, 32'h0, 1'b1);
        directed(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        tick();

        // DIV pulse at E0+10 of a running MULT must be ignored
        start_op(1, 0, 32'd5, 32'd5);
        repeat (9) tick();
        start_op(0, 1, 32'd100, 32'd7);
        wait_rdy(n);
        chk("ignored_latency", n, 23);
        chk("ignored_result", data_result, 32'd25);
        // back-to-back start in the DONE cycle
        directed(1, 0, 32'd3, 32'd4, 32'd12, 1'b0);
        directed(1, 1, 32'd9, 32'd3, 32'd27, 1'b0);
        tick();

        // reset mid-divide
        start_op(0, 1, 32'd1000, 32'd7);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_result", data_result, 32'h0);
        chk("midreset_flags", {29'b0, data_exception, data_resultRDY, busy}, 32'h0);
        rdy_cnt = 0;
        repeat (40) begin
            tick();
            if (data_resultRDY) rdy_cnt++;
        end
        chk("midreset_no_rdy", rdy_cnt, 0);
        directed(1, 0, 32'd2, 32'd2, 32'd4, 1'b0);

        // randomized operations with spurious start pulses while busy
        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            mul = 1'($urandom_range(0, 1));
            div = mul ? 1'($urandom_range(0, 1)) : 1'b1;
            start_op(mul, div, rnd_val(), rnd_val());
            n = 0;
            for (int i = 1; i <= 40; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    data_operandA = rnd_val();
                    data_operandB = rnd_val();
                    ctrl_MULT = 1'($urandom_range(0, 1));
                    ctrl_DIV  = ~ctrl_MULT;
                end
                tick();
                ctrl_MULT = 1'b0;
                ctrl_DIV  = 1'b0;
                if (data_resultRDY) begin
                    n = i;
                    break;
                end
            end
            chk("rand_latency", n, 33);
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Iterative multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage and handles MUL/DIV instructions.
- Latches two 32-bit signed operands on a one-cycle command pulse.
- Runs a fixed-length radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop over a shared WIDTH+1-bit adder.
- Returns a registered result with a one-cycle ready pulse and an exception flag.
- The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
data_operandA  in  WIDTH  multiplicand / dividend (two's complement)
data_operandB  in  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  in  1  single-cycle start pulse for A*B
ctrl_DIV  in  1  single-cycle start pulse for A/B
data_result  out  WIDTH  low WIDTH bits of product, or quotient truncated toward zero
data_exception  out  1  overflow (MULT) or divide-by-zero / overflow (DIV)
data_resultRDY  out  1  high exactly one cycle when result is valid
busy  out  1  high while an operation is in progress (RUN, FIX)

Behaviour:
- Reset values:
  - state=IDLE.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Internal registers zero.
- States and transitions:
  - IDLE: start sampled → RUN.
  - RUN: WIDTH cycles, then → FIX.
  - FIX: one cycle → DONE.
  - DONE: one cycle → IDLE, or → RUN if a new start is sampled.
- Start rules:
  - Start is sampled only in IDLE or DONE.
  - ctrl_MULT and ctrl_DIV are ignored during RUN/FIX; no queueing.
  - Both high together: MULT wins, DIV dropped.
- Operand capture at the start edge E0:
  - Operands are stored as magnitudes |A|, |B| in WIDTH bits. |−2^31| = 0x80000000 unsigned, which is legal.
  - Result sign stored as A[31]^B[31].
  - For DIV, a div-by-zero flag is stored if B==0.
- RUN, multiply: each cycle, if multiplier LSB=1 add multiplicand into the upper half of a 2*WIDTH accumulator, then shift right 1.
- RUN, divide: each cycle, shift the remainder/quotient pair left 1 and trial-subtract the divisor. If non-negative, commit and set quotient bit = 1; else restore and set bit = 0.
- A 5-bit iteration counter counts 0..WIDTH-1; RUN exits when counter = WIDTH-1 after that cycle's step.
- FIX cycle:
  - Negate the magnitude result if the sign flag is set.
  - MULT exception = 1 iff the signed 64-bit true product is outside [−2^31, 2^31−1]. data_result still carries the low 32 bits of the signed product.
  - DIV exception = 1 iff B==0 (data_result=0) or A=−2^31 with B=−1 (data_result=0x80000000).
  - Remainder is discarded. Quotient truncates toward zero, e.g. −7/2 = −3.
- DONE:
  - data_result and data_exception are registered at the FIX→DONE edge, i.e. edge E0+WIDTH+1.
  - data_resultRDY=1 for exactly that one DONE cycle.
  - Latency from the start-sampling edge to RDY visible is WIDTH+1 edges (33 for WIDTH=32).
- Output hold: data_result and data_exception hold until the next operation's FIX→DONE edge. They are not cleared on RDY fall.
- busy is 1 from the edge after E0 through the end of the FIX cycle, and 0 in IDLE and DONE.
- Back-to-back: a start in the DONE cycle begins a new operation. RDY still pulses only once for the previous operation.
- Reset mid-operation: the next edge forces IDLE, clears all outputs, and produces no RDY pulse. Reset wins over a simultaneous start.

Test Plan:
- MULT A=7, B=−6, start at E0 → data_resultRDY high only in the cycle after E0+33, data_result=0xFFFFFFD6 (−42), exception=0, busy low after.
- MULT A=0x7FFFFFFF, B=2 → data_result=0xFFFFFFFE, exception=1; then MULT A=−65536, B=32768 → data_result=0x80000000, exception=0.
- DIV A=−7, B=2 → result=0xFFFFFFFD (−3), exception=0; DIV A=100, B=0 → result=0, exception=1; DIV A=0x80000000, B=−1 → result=0x80000000, exception=1.
- ctrl_DIV pulse at E0+10 during a running MULT (5*5) → ignored, result=25, exactly one RDY pulse; start in the DONE cycle (MULT 3*4) → second RDY 33 edges later, result=12.
- ctrl_MULT and ctrl_DIV both high with A=9, B=3 → result=27 (multiply taken).
- reset asserted at E0+15 of a DIV → next cycle outputs all 0, busy=0, no RDY within the following 40 cycles; a fresh MULT 2*2 then completes normally with result=4.
